// File: rtl/axi_lite_arb.sv
// axi_lite_arb: two requesters share one AXI4-Lite master port.
// Only one transaction is in flight at a time. Every output comes from a register.
//
// Ports
//   aclk, areset          single clock; synchronous active-high reset
//   req_valid/req_ready   per-requester request and one-cycle accept pulse
//   req_write/addr/wdata  per-requester request fields (requester 1 in the upper half)
//   rsp_valid/rdata/resp  one-cycle completion pulse, with shared data and response
//   m_axi_*               AXI4-Lite master: AW, W, B, AR and R channels
//
// Configuration
//   AXI_LITE_ARB_RR_EN    When defined, contention is arbitrated round-robin.
//                         When undefined, requester 0 always wins contention.
module axi_lite_arb #(
    parameter logic [2:0] PROT  = 3'b000,
    parameter logic [3:0] WSTRB = 4'hF
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, DONE} state_t;

    state_t      state_q;
    logic        gnt_q;
    logic        gnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [1:0]  req_ready_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_resp_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;
`ifdef AXI_LITE_ARB_RR_EN
    logic        last_q;
`endif

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = awvalid_q && m_axi_awready;
    assign w_hs  = wvalid_q  && m_axi_wready;
    assign ar_hs = arvalid_q && m_axi_arready;

    // Grant selection. Only used in IDLE when at least one req_valid is high.
    always_comb begin
        gnt_d = 1'b0;
`ifdef AXI_LITE_ARB_RR_EN
        if (&req_valid) gnt_d = ~last_q;        // contention: not the last one granted
        else            gnt_d = ~req_valid[0];
`else
        gnt_d = ~req_valid[0];                  // requester 0 wins ties
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`ifdef AXI_LITE_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            // Both of these are single-cycle pulses.
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        gnt_q       <= gnt_d;
                        req_ready_q <= gnt_d ? 2'b10 : 2'b01;
                        addr_q      <= gnt_d ? req_addr[63:32]  : req_addr[31:0];
                        wdata_q     <= gnt_d ? req_wdata[63:32] : req_wdata[31:0];
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
`ifdef AXI_LITE_ARB_RR_EN
                        last_q      <= gnt_d;
`endif
                        // The direction is held in the state, so no separate write flag is kept.
                        state_q     <= req_write[gnt_d] ? WADDR : RADDR;
                    end
                end
                WADDR: begin
                    // AW and W complete independently. The first cycle in this
                    // state raises both valids, one cycle after req_ready.
                    if (aw_hs)           begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
                    else if (!aw_done_q) awvalid_q <= 1'b1;
                    if (w_hs)            begin wvalid_q <= 1'b0; w_done_q <= 1'b1; end
                    else if (!w_done_q)  wvalid_q <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bready_q && m_axi_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi_bresp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        state_q     <= DONE;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RRESP;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                RRESP: begin
                    if (rready_q && m_axi_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= m_axi_rresp;
                        rsp_rdata_q <= m_axi_rdata;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        state_q     <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;   // rsp_valid is visible during this cycle
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = WSTRB;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = PROT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_arb.sv
module tb_axi_lite_arb;
    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_resp;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 aclk = ~aclk;

    axi_lite_arb dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model, with per-channel delays set by the directed steps.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_c = 2'b00, r_resp_c = 2'b00;
    logic [31:0] r_data_c = '0;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;
    int          aw_hs_n = 0, w_hs_n = 0;

    always @(posedge aclk) begin
        if (areset) begin
            awready <= 0; wready <= 0; bvalid <= 0; arready <= 0; rvalid <= 0;
            bresp <= 0; rresp <= 0; rdata <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; ar_got <= 0;
        end else begin
            if (m_axi_awvalid && awready) begin awready <= 0; aw_got <= 1; end
            else if (m_axi_awvalid) begin
                if (aw_cnt == aw_dly) begin awready <= 1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (m_axi_wvalid && wready) begin wready <= 0; w_got <= 1; end
            else if (m_axi_wvalid) begin
                if (w_cnt == w_dly) begin wready <= 1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (bvalid) begin
                if (m_axi_bready) bvalid <= 0;
            end else if (aw_got && w_got) begin
                if (b_cnt == b_dly) begin
                    bvalid <= 1; bresp <= b_resp_c; aw_got <= 0; w_got <= 0; b_cnt <= 0;
                end else b_cnt <= b_cnt + 1;
            end
            if (m_axi_arvalid && arready) begin arready <= 0; ar_got <= 1; end
            else if (m_axi_arvalid) begin
                if (ar_cnt == ar_dly) begin arready <= 1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end
            if (rvalid) begin
                if (m_axi_rready) rvalid <= 0;
            end else if (ar_got) begin
                if (r_cnt == r_dly) begin
                    rvalid <= 1; rdata <= r_data_c; rresp <= r_resp_c; ar_got <= 0; r_cnt <= 0;
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    always @(posedge aclk) begin
        if (!areset && m_axi_awvalid && awready) aw_hs_n <= aw_hs_n + 1;
        if (!areset && m_axi_wvalid && wready)   w_hs_n  <= w_hs_n + 1;
    end

    // Scoreboard of expected completions, plus a log of the grants seen.
    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [1:0] grants[$];

    always @(negedge aclk) begin
        if (!areset && rsp_valid != 2'b00) begin
            if (sb.size() == 0) check("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
            else begin
                mon_e = sb.pop_front();
                check("rsp_valid", {62'd0, rsp_valid}, {62'd0, mon_e.who});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, mon_e.rdata});
                check("rsp_resp",  {62'd0, rsp_resp},  {62'd0, mon_e.resp});
            end
        end
        if (!areset && req_ready != 2'b00) grants.push_back(req_ready);
    end

    function automatic logic [63:0] all_outs();
        return {21'd0, req_ready, rsp_valid, rsp_rdata, rsp_resp,
                m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};
    endfunction

    // Present a request and wait, with a bound, for its accept pulse. On return we are at the negedge where req_ready is seen.
    task automatic issue(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit push, input exp_t e);
        bit seen = 0;
        @(negedge aclk);
        req_valid[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = data;
        if (push) sb.push_back(e);
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (req_ready[idx]) begin seen = 1; break; end
        end
        req_valid[idx] = 1'b0;
        check("req_ready_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge aclk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw0, w0, n;
        bit ok;
        logic [1:0] gexp [4];

        areset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset_outs", all_outs(), 64'd0);
        check("wstrb",  {60'd0, m_axi_wstrb},  64'hF);
        check("awprot", {61'd0, m_axi_awprot}, 64'd0);
        check("arprot", {61'd0, m_axi_arprot}, 64'd0);
        @(negedge aclk);
        areset = 0;

        // req0 write. AW and W are accepted in the same cycle; B comes back two cycles later.
        aw_dly = 0; w_dly = 0; b_dly = 1; b_resp_c = 2'b00;
        aw0 = aw_hs_n; w0 = w_hs_n;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1, '{who: 2'b01, rdata: 32'd0, resp: 2'b00});
        @(negedge aclk);
        check("lat_awvalid", {63'd0, m_axi_awvalid}, 64'd1);
        check("lat_wvalid",  {63'd0, m_axi_wvalid},  64'd1);
        check("awaddr", {32'd0, m_axi_awaddr}, 64'h10);
        check("wdata",  {32'd0, m_axi_wdata},  64'hDEADBEEF);
        check("req_ready_pulse", {62'd0, req_ready}, 64'd0);
        wait_sb();
        check("aw_beats", 64'(aw_hs_n - aw0), 64'd1);
        check("w_beats",  64'(w_hs_n - w0),   64'd1);

        // req1 read. arready is delayed, and the slave returns a nonzero rresp.
        ar_dly = 3; r_dly = 0; r_data_c = 32'h12345678; r_resp_c = 2'b10;
        issue(1, 1'b0, 32'h20, 32'h0, 1, '{who: 2'b10, rdata: 32'h12345678, resp: 2'b10});
        @(negedge aclk);
        check("arvalid", {63'd0, m_axi_arvalid}, 64'd1);
        check("araddr",  {32'd0, m_axi_araddr},  64'h20);
        check("no_aw_on_read", {63'd0, m_axi_awvalid}, 64'd0);
        wait_sb();

        // Write where wready arrives 4 cycles before awready.
        aw_dly = 4; w_dly = 0; b_dly = 0;
        aw0 = aw_hs_n; w0 = w_hs_n;
        issue(0, 1'b1, 32'h30, 32'hCAFEF00D, 1, '{who: 2'b01, rdata: 32'd0, resp: 2'b00});
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (w_hs_n != w0) begin ok = 1; break; end
        end
        check("w_hs_seen", {63'd0, ok}, 64'd1);
        check("wvalid_dropped", {63'd0, m_axi_wvalid},  64'd0);
        check("awvalid_held",   {63'd0, m_axi_awvalid}, 64'd1);
        check("no_wresp_early", {63'd0, m_axi_bready},  64'd0);
        @(negedge aclk);
        check("awvalid_held2",   {63'd0, m_axi_awvalid}, 64'd1);
        check("no_wresp_early2", {63'd0, m_axi_bready},  64'd0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (aw_hs_n != aw0) begin ok = 1; break; end
            @(negedge aclk);
        end
        check("aw_hs_seen", {63'd0, ok}, 64'd1);
        check("wresp_after_aw", {63'd0, m_axi_bready}, 64'd1);
        wait_sb();
        check("w_beats_once", 64'(w_hs_n - w0), 64'd1);

        // Assert reset while in WRESP. The aborted write never produces a response.
        b_dly = 6;
        aw_dly = 0;
        issue(0, 1'b1, 32'h40, 32'h11111111, 0, '{who: 2'b00, rdata: 32'd0, resp: 2'b00});
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (m_axi_bready) begin ok = 1; break; end
        end
        check("in_wresp", {63'd0, ok}, 64'd1);
        areset = 1;
        @(posedge aclk);
        #1;
        check("abort_outs", all_outs(), 64'd0);
        @(negedge aclk);
        areset = 0;
        b_dly = 1; b_resp_c = 2'b01;
        issue(1, 1'b1, 32'h44, 32'h22222222, 1, '{who: 2'b10, rdata: 32'd0, resp: 2'b01});
        wait_sb();

        // Both requesters held valid for four reads.
`ifdef AXI_LITE_ARB_RR_EN
        gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
`else
        gexp[0] = 2'b01; gexp[1] = 2'b01; gexp[2] = 2'b01; gexp[3] = 2'b01;
`endif
        ar_dly = 0; r_dly = 1; r_data_c = 32'hA5A50000; r_resp_c = 2'b00;
        grants.delete();
        for (int i = 0; i < 4; i++) sb.push_back('{who: gexp[i], rdata: 32'hA5A50000, resp: 2'b00});
        @(negedge aclk);
        req_write = 2'b00; req_addr = {32'h104, 32'h100}; req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge aclk);
            if (req_ready != 2'b00) n++;
            if (n == 4) break;
        end
        req_valid = 2'b00;
        check("contention_grants", 64'(n), 64'd4);
        wait_sb();
        check("grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("grant_%0d", i), {62'd0, grants[i]}, {62'd0, gexp[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
